// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
// Program-counter generation and fetch-request stage in front of the IFU.
// It holds the architectural fetch PC and presents it to the IFU with a
// valid/ready handshake. The PC advances by 4 after each accepted fetch, or
// jumps on a redirect or trap. A misaligned redirect target, or a halt
// request, stops fetch permanently until reset.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   i_ifu_ready        IFU accepts o_pc this cycle
//   i_stall            hold the PC (hazard/backpressure)
//   i_redirect_valid   branch/jump taken; target on i_redirect_pc
//   i_trap_valid       trap entry/return; target on i_trap_pc (low bits dropped)
//   i_halt             ebreak / simulation end
//   o_pc, o_pc_valid   fetch request to the IFU
//   o_misalign         sticky flag: a redirect target was not 4-byte aligned
//   o_bad_addr         the offending redirect target
//   o_halted           fetch stopped until reset
//   o_fetch_cnt        count of accepted fetch handshakes
module pc_fetch_ctrl #(
  parameter int                   CPU_WIDTH = 64,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ifu_ready,
  input  logic                 i_stall,
  input  logic                 i_redirect_valid,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  input  logic                 i_trap_valid,
  input  logic [CPU_WIDTH-1:0] i_trap_pc,
  input  logic                 i_halt,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_pc_valid,
  output logic                 o_misalign,
  output logic [CPU_WIDTH-1:0] o_bad_addr,
  output logic                 o_halted,
  output logic [63:0]          o_fetch_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t               state;
  logic                 hs;
  logic [CPU_WIDTH-1:0] trap_tgt;

  assign hs       = o_pc_valid && i_ifu_ready;
  // Trap targets are forced to word alignment, so they never fault.
  assign trap_tgt = i_trap_pc & ~CPU_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      o_pc        <= RESET_PC;
      o_pc_valid  <= 1'b0;
      o_misalign  <= 1'b0;
      o_bad_addr  <= '0;
      o_halted    <= 1'b0;
      o_fetch_cnt <= '0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          o_pc       <= RESET_PC;
          o_pc_valid <= 1'b1;
        end
        RUN: begin
          // The handshake counts even when the PC is redirected the same
          // cycle: the IFU did accept the old request.
          if (hs) o_fetch_cnt <= o_fetch_cnt + 64'd1;
          if (i_halt) begin
            state      <= HALT;
            o_pc_valid <= 1'b0;
            o_halted   <= 1'b1;
          end else if (i_trap_valid) begin
            o_pc <= trap_tgt;
          end else if (i_redirect_valid) begin
            if (i_redirect_pc[1:0] == 2'b00) begin
              o_pc <= i_redirect_pc;
            end else begin
              state      <= HALT;
              o_pc_valid <= 1'b0;
              o_halted   <= 1'b1;
              o_misalign <= 1'b1;
              o_bad_addr <= i_redirect_pc;
            end
          end else if (!i_stall && hs) begin
            o_pc <= o_pc + CPU_WIDTH'(4);
          end
        end
        HALT: begin
          // Terminal state: every input is ignored until reset.
          o_pc_valid <= 1'b0;
          o_halted   <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, ready, stall, rv, tv, halt;
  logic [63:0] rpc, tpc;
  logic [63:0] pc, bad, cnt;
  logic        pcv, mis, hlt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.CPU_WIDTH(64), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .i_ifu_ready(ready), .i_stall(stall),
    .i_redirect_valid(rv), .i_redirect_pc(rpc),
    .i_trap_valid(tv), .i_trap_pc(tpc),
    .i_halt(halt),
    .o_pc(pc), .o_pc_valid(pcv), .o_misalign(mis), .o_bad_addr(bad),
    .o_halted(hlt), .o_fetch_cnt(cnt)
  );

  typedef struct {
    logic        rst, ready, stall, rv, tv, halt;
    logic [63:0] rpc, tpc;
    logic [63:0] pc, bad, cnt;
    logic        v, mis, hlt;
    string       name;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string name, logic r, logic rd, logic st,
                              logic rvv, logic [63:0] rp, logic tvv, logic [63:0] tp,
                              logic h, logic [63:0] epc, logic ev, logic em,
                              logic [63:0] eb, logic eh, logic [63:0] ec);
    vec_t x;
    x.name = name; x.rst = r; x.ready = rd; x.stall = st; x.rv = rvv; x.rpc = rp;
    x.tv = tvv; x.tpc = tp; x.halt = h; x.pc = epc; x.v = ev; x.mis = em;
    x.bad = eb; x.hlt = eh; x.cnt = ec;
    return x;
  endfunction

  task automatic chk(string name, string fld, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare after the edge.
  task automatic step(vec_t x);
    vec_t e;
    rst = x.rst; ready = x.ready; stall = x.stall; rv = x.rv; rpc = x.rpc;
    tv = x.tv; tpc = x.tpc; halt = x.halt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.name, "pc", pc, e.pc);
    chk(e.name, "valid", {63'd0, pcv}, {63'd0, e.v});
    chk(e.name, "misalign", {63'd0, mis}, {63'd0, e.mis});
    chk(e.name, "bad_addr", bad, e.bad);
    chk(e.name, "halted", {63'd0, hlt}, {63'd0, e.hlt});
    chk(e.name, "fetch_cnt", cnt, e.cnt);
  endtask

  localparam logic [63:0] RP  = 64'h8000_0000;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  initial begin
    rst = 1'b1; ready = 0; stall = 0; rv = 0; tv = 0; halt = 0; rpc = '0; tpc = '0;

    //                 name       rst rdy stl rv rpc               tv tpc              hlt  pc               v  mis bad            hlt cnt
    tbl.push_back(mk("reset",     1, 0, 0, 0, 64'd0,           0, 64'd0,           0, RP,              0, 0, 64'd0,          0, 64'd0));
    tbl.push_back(mk("boot",      0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP,              1, 0, 64'd0,          0, 64'd0));
    tbl.push_back(mk("seq1",      0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h4,      1, 0, 64'd0,          0, 64'd1));
    tbl.push_back(mk("seq2",      0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h8,      1, 0, 64'd0,          0, 64'd2));
    tbl.push_back(mk("seq3",      0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'hC,      1, 0, 64'd0,          0, 64'd3));
    tbl.push_back(mk("seq4",      0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h10,     1, 0, 64'd0,          0, 64'd4));
    tbl.push_back(mk("nrdy1",     0, 0, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h10,     1, 0, 64'd0,          0, 64'd4));
    tbl.push_back(mk("nrdy2",     0, 0, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h10,     1, 0, 64'd0,          0, 64'd4));
    tbl.push_back(mk("nrdy3",     0, 0, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h10,     1, 0, 64'd0,          0, 64'd4));
    tbl.push_back(mk("rdy_again", 0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP + 64'h14,     1, 0, 64'd0,          0, 64'd5));
    tbl.push_back(mk("stall",     0, 0, 1, 0, 64'd0,           0, 64'd0,           0, RP + 64'h14,     1, 0, 64'd0,          0, 64'd5));
    tbl.push_back(mk("stall_rd",  0, 0, 1, 1, RP + 64'h100,    0, 64'd0,           0, RP + 64'h100,    1, 0, 64'd0,          0, 64'd5));
    tbl.push_back(mk("trap_wins", 0, 0, 1, 1, RP + 64'h301,    1, RP + 64'h203,    0, RP + 64'h200,    1, 0, 64'd0,          0, 64'd5));
    tbl.push_back(mk("rd_top",    0, 1, 0, 1, TOP,             0, 64'd0,           0, TOP,             1, 0, 64'd0,          0, 64'd6));
    tbl.push_back(mk("wrap",      0, 1, 0, 0, 64'd0,           0, 64'd0,           0, 64'd0,           1, 0, 64'd0,          0, 64'd7));
    tbl.push_back(mk("post_wrap", 0, 1, 0, 0, 64'd0,           0, 64'd0,           0, 64'd4,           1, 0, 64'd0,          0, 64'd8));
    tbl.push_back(mk("halt_rd",   0, 0, 0, 1, RP + 64'h500,    0, 64'd0,           1, 64'd4,           0, 0, 64'd0,          1, 64'd8));
    tbl.push_back(mk("halt_ign",  0, 1, 0, 1, RP + 64'h600,    1, RP + 64'h700,    0, 64'd4,           0, 0, 64'd0,          1, 64'd8));
    tbl.push_back(mk("rst2",      1, 0, 0, 0, 64'd0,           0, 64'd0,           0, RP,              0, 0, 64'd0,          0, 64'd0));
    tbl.push_back(mk("boot2",     0, 0, 0, 0, 64'd0,           0, 64'd0,           0, RP,              1, 0, 64'd0,          0, 64'd0));
    tbl.push_back(mk("misalign",  0, 0, 0, 1, RP + 64'h102,    0, 64'd0,           0, RP,              0, 1, RP + 64'h102,   1, 64'd0));
    tbl.push_back(mk("mis_ign",   0, 1, 0, 1, RP + 64'h106,    0, 64'd0,           0, RP,              0, 1, RP + 64'h102,   1, 64'd0));
    tbl.push_back(mk("mis_ign2",  0, 1, 0, 0, 64'd0,           1, RP + 64'h800,    0, RP,              0, 1, RP + 64'h102,   1, 64'd0));
    tbl.push_back(mk("rst3",      1, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP,              0, 0, 64'd0,          0, 64'd0));
    tbl.push_back(mk("tr_rdy",    0, 1, 0, 0, 64'd0,           0, 64'd0,           0, RP,              1, 0, 64'd0,          0, 64'd0));
    tbl.push_back(mk("trap_hs",   0, 1, 0, 0, 64'd0,           1, RP + 64'h2002,   0, RP + 64'h2000,   1, 0, 64'd0,          0, 64'd1));

    foreach (tbl[i]) step(tbl[i]);

    // Mid-run reset: run from reset to PC 8000_0040 with 16 handshakes.
    step(mk("mr_rst",  1, 0, 0, 0, 64'd0, 0, 64'd0, 0, RP, 0, 0, 64'd0, 0, 64'd0));
    step(mk("mr_boot", 0, 1, 0, 0, 64'd0, 0, 64'd0, 0, RP, 1, 0, 64'd0, 0, 64'd0));
    for (int k = 1; k <= 16; k++)
      step(mk("mr_run", 0, 1, 0, 0, 64'd0, 0, 64'd0, 0, RP + 64'(4 * k), 1, 0, 64'd0, 0, 64'(k)));
    chk("mr_at40", "pc", pc, 64'h8000_0040);
    chk("mr_at40", "fetch_cnt", cnt, 64'd16);
    step(mk("mr_rst_mid", 1, 1, 0, 0, 64'd0, 0, 64'd0, 0, RP, 0, 0, 64'd0, 0, 64'd0));
    step(mk("mr_first",   0, 1, 0, 0, 64'd0, 0, 64'd0, 0, RP, 1, 0, 64'd0, 0, 64'd0));
    step(mk("mr_next",    0, 1, 0, 0, 64'd0, 0, 64'd0, 0, RP + 64'h4, 1, 0, 64'd0, 0, 64'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter generation and fetch-request stage sitting directly upstream of the IFU. Holds the architectural fetch PC, presents it to the IFU with a valid/ready handshake, and advances it sequentially, or redirects it on branch/jump or trap. Detects misaligned redirect targets and halts fetch on `ebreak`/halt requests. Provides a retired-fetch counter for difftest and debug.

## Interface

- `CPU_WIDTH`, 64, PC and data width in bits.
- `RESET_PC`, 64'h8000_0000, first fetch address after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_ifu_ready`  in  1  IFU accepts `o_pc` this cycle.
- `i_stall`  in  1  hold the PC; no advance (hazard/backpressure from IDU/EXU).
- `i_redirect_valid`  in  1  branch/jump taken this cycle.
- `i_redirect_pc`  in  CPU_WIDTH  redirect target.
- `i_trap_valid`  in  1  exception/ecall/mret entry this cycle.
- `i_trap_pc`  in  CPU_WIDTH  trap target (mtvec/mepc).
- `i_halt`  in  1  ebreak/simulation-end request.
- `o_pc`  out  CPU_WIDTH  current fetch address to IFU.
- `o_pc_valid`  out  1  `o_pc` is a valid fetch request.
- `o_misalign`  out  1  sticky: a redirect target had bits [1:0] != 0.
- `o_bad_addr`  out  CPU_WIDTH  offending redirect target, captured with `o_misalign`.
- `o_halted`  out  1  fetch permanently stopped until reset.
- `o_fetch_cnt`  out  64  number of accepted fetch handshakes.

## Operation

- States: BOOT, RUN, HALT. All outputs registered.
- BOOT: entered on `rst`; `o_pc_valid`=0; unconditionally RUN next cycle with `o_pc`=RESET_PC.
- RUN: `o_pc_valid`=1. Handshake = `o_pc_valid && i_ifu_ready`.
- Next-PC priority in RUN (highest first):
  - `i_halt` -> HALT; `o_pc` holds.
  - `i_trap_valid` -> `o_pc` <= {`i_trap_pc`[63:2], 2'b00} (low bits forced to zero, never misaligned).
  - `i_redirect_valid`, target[1:0]==0 -> `o_pc` <= `i_redirect_pc`.
  - `i_redirect_valid`, target[1:0]!=0 -> `o_misalign`<=1, `o_bad_addr`<=target, -> HALT; `o_pc` holds.
  - `i_stall` -> hold.
  - handshake -> `o_pc` <= `o_pc` + 4, modulo 2^CPU_WIDTH (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
  - otherwise hold (IFU not ready).
- Trap/redirect take effect regardless of `i_stall` or `i_ifu_ready`; the in-flight PC is discarded.
- `o_fetch_cnt` increments by 1 on every handshake in RUN, including the cycle a redirect is taken; wraps modulo 2^64.
- HALT: `o_pc_valid`=0, `o_halted`=1; all inputs ignored; exits only via `rst`.
- No C extension: only 4-byte alignment is legal.

## Timing

- Reset values: `o_pc`=RESET_PC, `o_pc_valid`=0, `o_misalign`=0, `o_bad_addr`=0, `o_halted`=0, `o_fetch_cnt`=0, state BOOT.
- First valid fetch: cycle 1 after `rst` deasserts (BOOT lasts exactly one cycle).
- Redirect/trap latency: asserted in cycle N -> new `o_pc` visible, valid, in cycle N+1.
- Sequential advance: handshake in cycle N -> `o_pc`+4 in N+1; sustained `i_ifu_ready`=1 yields one new PC per cycle.
- Halt/misalign: asserted in N -> `o_pc_valid`=0, `o_halted`=1 in N+1; `o_misalign` and `o_bad_addr` update in N+1 and stay until reset.
- Simultaneous trap + redirect: trap wins; redirect target is not alignment-checked.
- Simultaneous halt + trap/redirect: halt wins; `o_pc` unchanged.
- `rst` mid-operation (any state): next edge restores all reset values; `o_fetch_cnt` cleared.
- `o_pc` and `o_pc_valid` never change while `o_pc_valid`=1, `i_ifu_ready`=0, and there is no redirect, trap, or halt.

## Test plan

- Reset release, `i_ifu_ready`=1 for 4 cycles -> `o_pc_valid` goes 0,1,1,1,1; `o_pc` goes 8000_0000, 8000_0000, 8000_0004, 8000_0008, 8000_000C; `o_fetch_cnt`=3 after cycle 4.
- `i_ifu_ready`=0 for 3 cycles at PC 8000_0010 -> `o_pc` holds 8000_0010, valid stays 1, counter unchanged; ready=1 -> 8000_0014 next cycle.
- `i_stall`=1 with `i_redirect_valid`=1, target 8000_0100 -> `o_pc`=8000_0100 next cycle. Same cycle `i_trap_valid`=1, `i_trap_pc`=8000_0203 -> `o_pc`=8000_0200 instead.
- Redirect to 8000_0102 -> next cycle `o_misalign`=1, `o_bad_addr`=8000_0102, `o_halted`=1, `o_pc_valid`=0; later redirects are ignored; `rst` clears all three.
- Redirect to FFFF_FFFF_FFFF_FFFC, then one handshake -> `o_pc`=0; `i_halt` with a simultaneous redirect -> HALT, `o_pc` unchanged.
- Assert `rst` for one cycle mid-run at PC 8000_0040 with count 16 -> reset values next cycle; first valid fetch at 8000_0000 one cycle later.
